// File: rtl/cascade_timer_if.sv
// cascade_timer_if: bundles the control, status, snapshot and alarm signals
// of the cascaded timebase so they travel as one port.
//   master : the client side (drives en/clear/limits/requests, reads counts)
//   slave  : the timer side (the reverse directions)
// STAGES and W must match the parameters of the cascade_timer instance.
interface cascade_timer_if #(
  parameter int STAGES = 6,
  parameter int W      = 8
);
  logic                  en;
  logic                  clear;
  logic [STAGES*W-1:0]   stage_max;
  logic [STAGES*W-1:0]   cnt;
  logic                  carry_out;
  logic                  ovf;
  logic                  ovf_clr;
  logic                  snap;
  logic [STAGES*W-1:0]   snap_cnt;
  logic                  snap_valid;
  logic                  alarm_en;
  logic [STAGES*W-1:0]   alarm_val;
  logic                  alarm;

  modport master (
    output en, clear, stage_max, ovf_clr, snap, alarm_en, alarm_val,
    input  cnt, carry_out, ovf, snap_cnt, snap_valid, alarm
  );

  modport slave (
    input  en, clear, stage_max, ovf_clr, snap, alarm_en, alarm_val,
    output cnt, carry_out, ovf, snap_cnt, snap_valid, alarm
  );
endinterface

// File: rtl/cascade_timer.sv
// cascade_timer: mixed-radix timebase built from STAGES cascaded counters,
// each with a runtime-programmable wrap value. All stages advance in the
// same edge their lower neighbours carry (no rippled, registered carries).
// Adds a sticky overflow flag, a coherent snapshot and a one-shot alarm.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cascade_timer_if.slave
//          en/clear        count enable / synchronous clear of counts
//          stage_max       per-stage wrap value, stage i at [i*W +: W]
//          cnt/carry_out   live count / combinational top-stage wrap
//          ovf/ovf_clr     sticky overflow flag and its clear
//          snap/snap_cnt/snap_valid  snapshot request, capture, valid pulse
//          alarm_en/alarm_val/alarm  compare alarm enable, value, pulse
module cascade_timer #(
  parameter int STAGES = 6,
  parameter int W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  cascade_timer_if.slave bus
);

  logic [STAGES*W-1:0] cnt_r;
  logic [STAGES*W-1:0] snap_cnt_r;
  logic [STAGES-1:0]   wrap;
  logic [STAGES-1:0]   inc;
  logic                carry;
  logic                ovf_r;
  logic                snap_valid_r;
  logic                match;
  logic                match_d;
  logic                alarm_r;

  // A stage increments when en is high and every stage below it is at its
  // wrap value; expressing it as an AND over all lower wraps keeps the
  // chain free of combinational feedback through a single vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign wrap[i] = (cnt_r[i*W +: W] >= bus.stage_max[i*W +: W]);
    if (i == 0) begin : g_first
      assign inc[i] = bus.en;
    end else begin : g_upper
      assign inc[i] = bus.en & (&wrap[i-1:0]);
    end
  end

  // Clear suppresses the carry so ovf cannot be set by a cleared wrap.
  assign carry = inc[STAGES-1] & wrap[STAGES-1] & ~bus.clear;

  // A stage already above a freshly lowered limit wraps on its next
  // increment rather than being corrected immediately.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      cnt_r <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (inc[i]) begin
          cnt_r[i*W +: W] <= wrap[i] ? '0 : cnt_r[i*W +: W] + W'(1);
        end
      end
    end
  end

  // Setting the flag takes precedence over a simultaneous clear request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (carry) begin
      ovf_r <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  // Capture uses the registered count, i.e. the value before this edge's
  // increment or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_cnt_r   <= '0;
      snap_valid_r <= 1'b0;
    end else begin
      snap_valid_r <= bus.snap;
      if (bus.snap) begin
        snap_cnt_r <= cnt_r;
      end
    end
  end

  // Edge-detect on the match so a held count produces only one pulse.
  assign match = bus.alarm_en & (cnt_r == bus.alarm_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      match_d <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      match_d <= match;
      alarm_r <= match & ~match_d;
    end
  end

  assign bus.cnt        = cnt_r;
  assign bus.carry_out  = carry;
  assign bus.ovf        = ovf_r;
  assign bus.snap_cnt   = snap_cnt_r;
  assign bus.snap_valid = snap_valid_r;
  assign bus.alarm      = alarm_r;

endmodule

// File: tb/tb_cascade_timer.sv
// tb_cascade_timer: directed testbench for cascade_timer with STAGES=3, W=4
// and limits {3,5,9} (stage2,stage1,stage0), giving a 240-cycle period.
module tb_cascade_timer;

  localparam int STAGES = 3;
  localparam int W      = 4;
  localparam logic [11:0] MAX_DEF = 12'h359;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  cascade_timer_if #(.STAGES(STAGES), .W(W)) ct_if ();

  cascade_timer #(.STAGES(STAGES), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ct_if.slave)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ct_if.en        = 1'b0;
    ct_if.clear     = 1'b0;
    ct_if.stage_max = MAX_DEF;
    ct_if.ovf_clr   = 1'b0;
    ct_if.snap      = 1'b0;
    ct_if.alarm_en  = 1'b0;
    ct_if.alarm_val = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    checks++;
    if (ct_if.cnt !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_cnt: got %h expected %h", ct_if.cnt, 12'h000);
    end
    checks++;
    if (ct_if.ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ct_if.ovf);
    end
    checks++;
    if (ct_if.snap_cnt !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_snap_cnt: got %h expected 000", ct_if.snap_cnt);
    end
    checks++;
    if (ct_if.snap_valid !== 1'b0 || ct_if.alarm !== 1'b0 || ct_if.carry_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got sv=%b al=%b co=%b expected 0 0 0",
               ct_if.snap_valid, ct_if.alarm, ct_if.carry_out);
    end
  endtask

  task automatic test_full_period();
    logic [11:0] exp_cnt;
    ct_if.en = 1'b1;
    for (int k = 0; k < 240; k++) begin
      exp_cnt = {4'(k / 60), 4'((k / 10) % 6), 4'(k % 10)};
      checks++;
      if (ct_if.cnt !== exp_cnt) begin
        errors++; $display("[TB] FAIL period_cnt k=%0d: got %h expected %h", k, ct_if.cnt, exp_cnt);
      end
      checks++;
      if (ct_if.carry_out !== (k == 239)) begin
        errors++; $display("[TB] FAIL period_carry k=%0d: got %b expected %b", k, ct_if.carry_out, (k == 239));
      end
      checks++;
      if (ct_if.ovf !== 1'b0) begin
        errors++; $display("[TB] FAIL period_ovf_early k=%0d: got %b expected 0", k, ct_if.ovf);
      end
      step();
    end
    ct_if.en = 1'b0;
    checks++;
    if (ct_if.cnt !== 12'h000) begin
      errors++; $display("[TB] FAIL period_wrap_cnt: got %h expected 000", ct_if.cnt);
    end
    checks++;
    if (ct_if.ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL period_ovf_set: got %b expected 1", ct_if.ovf);
    end
    ct_if.ovf_clr = 1'b1;
    step();
    ct_if.ovf_clr = 1'b0;
    checks++;
    if (ct_if.ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL period_ovf_clr: got %b expected 0", ct_if.ovf);
    end
  endtask

  task automatic test_carry_set_wins();
    ct_if.en = 1'b1;
    repeat (239) step();
    checks++;
    if (ct_if.cnt !== 12'h359) begin
      errors++; $display("[TB] FAIL preload_cnt: got %h expected 359", ct_if.cnt);
    end
    ct_if.ovf_clr = 1'b1;
    #1;
    checks++;
    if (ct_if.carry_out !== 1'b1) begin
      errors++; $display("[TB] FAIL full_carry: got %b expected 1", ct_if.carry_out);
    end
    step();
    ct_if.en      = 1'b0;
    ct_if.ovf_clr = 1'b0;
    checks++;
    if (ct_if.cnt !== 12'h000) begin
      errors++; $display("[TB] FAIL full_carry_cnt: got %h expected 000", ct_if.cnt);
    end
    checks++;
    if (ct_if.ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_set_wins: got %b expected 1", ct_if.ovf);
    end
    ct_if.ovf_clr = 1'b1;
    step();
    ct_if.ovf_clr = 1'b0;
    checks++;
    if (ct_if.ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_clr_after: got %b expected 0", ct_if.ovf);
    end
  endtask

  task automatic test_max_change();
    ct_if.en = 1'b1;
    repeat (7) step();
    checks++;
    if (ct_if.cnt !== 12'h007) begin
      errors++; $display("[TB] FAIL max_chg_pre: got %h expected 007", ct_if.cnt);
    end
    ct_if.stage_max = 12'h354;
    step();
    ct_if.en = 1'b0;
    checks++;
    if (ct_if.cnt !== 12'h010) begin
      errors++; $display("[TB] FAIL max_chg_wrap: got %h expected 010", ct_if.cnt);
    end
    ct_if.stage_max = MAX_DEF;
    ct_if.clear = 1'b1;
    ct_if.en    = 1'b1;
    step();
    ct_if.clear = 1'b0;
    ct_if.en    = 1'b0;
    checks++;
    if (ct_if.cnt !== 12'h000) begin
      errors++; $display("[TB] FAIL clear_over_en: got %h expected 000", ct_if.cnt);
    end
  endtask

  task automatic test_snapshot();
    ct_if.en = 1'b1;
    repeat (157) step();
    ct_if.snap = 1'b1;
    step();
    checks++;
    if (ct_if.snap_cnt !== 12'h237 || ct_if.snap_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL snap_first: got %h/%b expected 237/1", ct_if.snap_cnt, ct_if.snap_valid);
    end
    checks++;
    if (ct_if.cnt !== 12'h238) begin
      errors++; $display("[TB] FAIL snap_live: got %h expected 238", ct_if.cnt);
    end
    step();
    checks++;
    if (ct_if.snap_cnt !== 12'h238 || ct_if.snap_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL snap_b2b: got %h/%b expected 238/1", ct_if.snap_cnt, ct_if.snap_valid);
    end
    ct_if.snap = 1'b0;
    ct_if.en   = 1'b0;
    step();
    checks++;
    if (ct_if.snap_valid !== 1'b0 || ct_if.snap_cnt !== 12'h238) begin
      errors++; $display("[TB] FAIL snap_idle: got %h/%b expected 238/0", ct_if.snap_cnt, ct_if.snap_valid);
    end
    ct_if.clear = 1'b1;
    step();
    ct_if.clear = 1'b0;
    ct_if.en    = 1'b1;
    repeat (157) step();
    ct_if.snap  = 1'b1;
    ct_if.clear = 1'b1;
    #1;
    checks++;
    if (ct_if.carry_out !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_carry: got %b expected 0", ct_if.carry_out);
    end
    step();
    ct_if.snap  = 1'b0;
    ct_if.clear = 1'b0;
    ct_if.en    = 1'b0;
    checks++;
    if (ct_if.snap_cnt !== 12'h237 || ct_if.cnt !== 12'h000 || ct_if.snap_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL snap_clear: got snap=%h cnt=%h sv=%b expected 237 000 1",
               ct_if.snap_cnt, ct_if.cnt, ct_if.snap_valid);
    end
  endtask

  task automatic test_alarm();
    int pulses;
    ct_if.alarm_val = 12'h015;
    ct_if.alarm_en  = 1'b1;
    ct_if.en        = 1'b1;
    pulses = 0;
    repeat (15) begin
      step();
      if (ct_if.alarm === 1'b1) pulses++;
    end
    ct_if.en = 1'b0;
    checks++;
    if (ct_if.cnt !== 12'h015 || pulses != 0) begin
      errors++; $display("[TB] FAIL alarm_approach: got cnt=%h pulses=%0d expected 015 0", ct_if.cnt, pulses);
    end
    step();
    checks++;
    if (ct_if.alarm !== 1'b1) begin
      errors++; $display("[TB] FAIL alarm_pulse: got %b expected 1", ct_if.alarm);
    end
    pulses = 0;
    repeat (4) begin
      step();
      if (ct_if.alarm !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("[TB] FAIL alarm_hold: got %0d extra pulses expected 0", pulses);
    end
    ct_if.alarm_en = 1'b0;
    step();
    ct_if.alarm_en = 1'b1;
    step();
    checks++;
    if (ct_if.alarm !== 1'b1) begin
      errors++; $display("[TB] FAIL alarm_rearm: got %b expected 1", ct_if.alarm);
    end
    step();
    checks++;
    if (ct_if.alarm !== 1'b0) begin
      errors++; $display("[TB] FAIL alarm_rearm_once: got %b expected 0", ct_if.alarm);
    end
  endtask

  task automatic test_reset_midrun();
    // Re-arm the alarm and force a full carry (all limits 0) in one edge.
    ct_if.alarm_en = 1'b0;
    step();
    ct_if.alarm_en  = 1'b1;
    ct_if.snap      = 1'b1;
    ct_if.en        = 1'b1;
    ct_if.stage_max = 12'h000;
    step();
    checks++;
    if (ct_if.ovf !== 1'b1 || ct_if.snap_valid !== 1'b1 || ct_if.alarm !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_rst_flags: got ovf=%b sv=%b al=%b expected 1 1 1",
               ct_if.ovf, ct_if.snap_valid, ct_if.alarm);
    end
    ct_if.stage_max = MAX_DEF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ct_if.snap     = 1'b0;
    ct_if.alarm_en = 1'b0;
    checks++;
    if (ct_if.ovf !== 1'b0 || ct_if.snap_valid !== 1'b0 || ct_if.alarm !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_flags: got ovf=%b sv=%b al=%b expected 0 0 0",
               ct_if.ovf, ct_if.snap_valid, ct_if.alarm);
    end
    checks++;
    if (ct_if.cnt !== 12'h000 || ct_if.snap_cnt !== 12'h000) begin
      errors++; $display("[TB] FAIL rst_counts: got cnt=%h snap=%h expected 000 000", ct_if.cnt, ct_if.snap_cnt);
    end
    repeat (3) step();
    ct_if.en = 1'b0;
    checks++;
    if (ct_if.cnt !== 12'h003) begin
      errors++; $display("[TB] FAIL rst_resume: got %h expected 003", ct_if.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_period();
    test_carry_set_wins();
    test_max_change();
    test_snapshot();
    test_alarm();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cascade_timer.md
Name: cascade_timer

Overview:
Parametrised mixed-radix timebase and the successor of the fixed clk/usec/msec/sec/min/h/day counter chain. It provides STAGES cascaded counters, each with a runtime-programmable wrap value. Every stage advances in the same cycle that the stages below it carry, so there is no per-stage registered-carry skew. It adds a sticky overflow flag, a coherent snapshot of all stages, and a one-shot compare alarm. It sits beside the hashing core and supplies elapsed-time and timeout measurement.

Parameters:
STAGES, 6, number of cascaded stages; stage 0 is the fastest; legal range 1..8.
W, 8, bit width of each stage counter; legal range 1..16.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  count enable; stage 0 advances on each cycle that en=1
clear  in  1  synchronous clear of all stage counts; flags and snapshot are kept
stage_max  in  STAGES*W  per-stage wrap value; stage i uses bits [i*W +: W]; stage i counts 0..max_i (period max_i+1)
cnt  out  STAGES*W  live count; stage i at [i*W +: W]
carry_out  out  1  combinational; high in the cycle the top stage wraps
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf
snap  in  1  snapshot request pulse
snap_cnt  out  STAGES*W  captured count
snap_valid  out  1  one-cycle pulse, the cycle after snap
alarm_en  in  1  enables the compare alarm
alarm_val  in  STAGES*W  compare value
alarm  out  1  one-cycle alarm pulse

Behaviour:
- Reset (rst=1, highest priority): cnt=0, ovf=0, snap_cnt=0, snap_valid=0, alarm=0, internal match history=0.
- Priority after rst: clear, then en. While clear=1, all stages load 0 and carry_out=0. clear does not affect ovf, snap_cnt or the alarm history.
- Increment enables:
  - inc_0 = en.
  - inc_i = inc_{i-1} AND wrap_{i-1}.
  - wrap_i = (cnt_i >= max_i), evaluated on the current registered value.
- Stage update when inc_i=1: next value is 0 if wrap_i, else cnt_i+1. When inc_i=0 the stage holds.
- Carry is combinational across all stages. Example: 9,5,3 with max {9,5,3} and en=1 gives 0,0,0 on the next edge.
- carry_out = inc_{STAGES-1} AND wrap_{STAGES-1}, and is 0 when clear=1.
- max_i=0: stage i stays 0 and passes a carry on every inc_i.
- Runtime change of stage_max: if cnt_i is already above the new max_i, the next inc_i wraps it to 0 and carries. There is no immediate correction.
- Width rule: the +1 wraps modulo 2^W. With max_i = 2^W-1 the stage behaves as a plain binary counter.
- ovf:
  - Set on the edge after carry_out=1.
  - Cleared by ovf_clr when carry_out=0.
  - If set and clear occur in the same cycle, set wins.
- Snapshot:
  - When snap=1, snap_cnt latches the current registered cnt (the value before this edge's increment) on that edge.
  - snap_valid=1 for exactly the following cycle. Back-to-back snap pulses give back-to-back captures.
  - If clear and snap are both high, the pre-clear value is captured.
- Alarm:
  - match = alarm_en AND (cnt == alarm_val), computed on the registered cnt.
  - alarm is registered: alarm = match AND NOT match_d, where match_d is match delayed one cycle. Result: one pulse per match entry, even when en=0 holds cnt steady.
  - alarm_en low clears match_d on the next edge.
- Latency:
  - cnt updates one edge after en.
  - snap_valid, alarm and ovf each lag their cause by one edge.
- No handshake back-pressure; all inputs are sampled every cycle.

Test Plan:
- Bench configuration for all scenarios: STAGES=3, W=4, stage_max={3,5,9} (stage2,stage1,stage0).
- Reset then en=1 for 240 cycles: cnt returns to 0 and carry_out pulses exactly at cycle 240 → ovf=1 from the next edge; ovf_clr for 1 cycle → ovf=0.
- Preload to 9,5,3 by counting, then one en cycle → cnt=0,0,0 in one edge; carry_out=1 in that cycle; ovf_clr asserted in the same cycle → ovf=1 (set wins).
- Count to stage0=7, change max0 from 9 to 4, en=1 → cnt0=0 and stage1 increments on the next edge.
- en=1 with snap pulsed when cnt=2,3,7 → snap_cnt=2,3,7 and snap_valid=1 one cycle later; snap and clear together → snap_cnt=2,3,7 and cnt=0.
- alarm_val=0,1,5 with alarm_en=1, count through it, then hold en=0 on the match → exactly one alarm pulse, the cycle after cnt first reaches 0,1,5.
- rst asserted mid-count with ovf=1, snap_valid=1 and alarm=1 → all outputs 0 on the next edge; en=1 resumes from 0,0,0.
